bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter for the 16-bit-address / 32-bit-data system bus. It sits between two bus masters (CPU and DMA/loader) and the address decoder that fans out to bram, spram, led and uart. It serialises transactions with round-robin fairness and holds the winning master's address and data stable for the whole transaction. It also times out reads to unmapped space, which never return valid, so no master can hang the bus.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles spent in WAIT without `s_rd_valid` before a read is aborted. Legal range 2..255.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `m0_addr`, `m1_addr`  in  16: master address, held stable while request is high.
- `m0_rd_en`, `m1_rd_en`  in  1: read request, level, held until `mX_rd_valid`.
- `m0_wr_en`, `m1_wr_en`  in  1: write request, level, held until `mX_wr_done`. `rd_en` and `wr_en` are never both high on one master.
- `m0_wr_data`, `m1_wr_data`  in  32: write data, held with request.
- `m0_rd_data`, `m1_rd_data`  out  32: read data, valid when `mX_rd_valid` is high.
- `m0_rd_valid`, `m1_rd_valid`  out  1: one-cycle read completion pulse.
- `m0_wr_done`, `m1_wr_done`  out  1: one-cycle write completion pulse.
- `s_addr`  out  16: slave-side address to the decoder.
- `s_rd_en`, `s_wr_en`  out  1: one-cycle strobes to the decoder.
- `s_wr_data`  out  32: slave-side write data.
- `s_rd_data`  in  32: read data from the decoder.
- `s_rd_valid`  in  1: read completion from the decoder.
- `grant`  out  2: one-hot current owner, `2'b00` when idle.
- `bus_err`  out  1: one-cycle pulse, coincident with `rd_valid` of a timed-out read.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample requests (`mX_rd_en | mX_wr_en`).
  - No request: stay in IDLE.
  - One request: grant it.
  - Both request: grant the master that is not `last`.
  - On grant, latch owner, addr, wr_data and direction into registers. Set `last` to the owner. Go to ISSUE.
- ISSUE:
  - Assert the `s_rd_en` or `s_wr_en` strobe for exactly this cycle.
  - Write: go to RESP.
  - Read: clear the timeout counter and go to WAIT.
- WAIT:
  - If `s_rd_valid`: latch `s_rd_data` and go to RESP.
  - Otherwise increment the counter. When counter == `TIMEOUT-1`, latch data 32'h0, set err, go to RESP.
- RESP:
  - Pulse the owner's `rd_valid` (read) or `wr_done` (write) for one cycle. `bus_err` pulses too if err is set.
  - Clear err. Go to IDLE.
- `s_addr`/`s_wr_data` come from the latched registers during ISSUE, WAIT and RESP. They are 0 in IDLE.
- `mX_rd_data` holds the last latched value. It is only meaningful during the pulse.
- `s_rd_valid` outside WAIT is ignored and does not disturb state or data.
- Request order of a single master is preserved. No transaction is ever issued twice or dropped, except on reset.
- Reset mid-transaction: the transaction is abandoned and no completion pulse is produced. Masters reissue after reset.

## Timing
- Reset values:
  - State IDLE, `last` = m1 (so m0 wins the first tie).
  - All outputs 0; counter 0; err 0; latched registers 0.
- Read latency, from the request first sampled in IDLE (cycle 0) to `mX_rd_valid`, is 3 + (slave latency − 1) cycles:
  - cycle 0: IDLE grant.
  - cycle 1: ISSUE, `s_rd_en`.
  - cycle 2: WAIT, `s_rd_valid` with bram.
  - cycle 3: RESP, `rd_valid`.
- Write: grant at cycle 0, `s_wr_en` at cycle 1, `wr_done` at cycle 2.
- Minimum bus occupancy:
  - Write: 3 cycles including IDLE.
  - Read: 4 cycles including IDLE.
- Timeout read: `rd_valid` + `bus_err` arrive `TIMEOUT` cycles after ISSUE, plus one RESP cycle.
- The master deasserts its request in the cycle after its completion pulse. The arbiter samples only in IDLE, so a request held one cycle late is not re-granted.
- A request that appears while the bus is busy waits. Worst-case wait is one full transaction of the other master.

## Test plan
- Single read: m0 reads 0x0010; slave returns 0xCAFEF00D one cycle after `s_rd_en` -> `s_rd_en` at cycle 1 with `s_addr`=0x0010, `m0_rd_valid` at cycle 3 with 0xCAFEF00D, `grant`=01 during cycles 1–3.
- Write: m1 writes 0x12345678 to 0x4000 -> `s_wr_en` one cycle with `s_wr_data`=0x12345678, `m1_wr_done` one cycle later, `m0_*` outputs stay 0.
- Simultaneous requests, both continuous, 6 transactions -> grants alternate m0, m1, m0, m1, m0, m1 after reset; no back-to-back grants to one master while the other waits.
- Timeout: m0 reads 0x3000 with `s_rd_valid` never asserted, `TIMEOUT`=16 -> `m0_rd_valid` with data 0 and `bus_err` high, both exactly 17 cycles after ISSUE; the next m1 request proceeds normally.
- Stray/late valid: `s_rd_valid` pulsed during IDLE and ISSUE -> no state change and no `mX_rd_valid`; the real valid in WAIT still returns the correct data.
- Reset in WAIT: assert `rst` for one cycle -> next cycle all outputs 0, `grant`=00, no completion pulse; a new m1 read completes in 4 cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the 16-bit address / 32-bit data system bus.
// Serialises CPU and DMA transactions and aborts reads to unmapped space after TIMEOUT cycles.
module bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [15:0] m0_addr,
    input  logic        m0_rd_en,
    input  logic        m0_wr_en,
    input  logic [31:0] m0_wr_data,
    output logic [31:0] m0_rd_data,
    output logic        m0_rd_valid,
    output logic        m0_wr_done,

    input  logic [15:0] m1_addr,
    input  logic        m1_rd_en,
    input  logic        m1_wr_en,
    input  logic [31:0] m1_wr_data,
    output logic [31:0] m1_rd_data,
    output logic        m1_rd_valid,
    output logic        m1_wr_done,

    output logic [15:0] s_addr,
    output logic        s_rd_en,
    output logic        s_wr_en,
    output logic [31:0] s_wr_data,
    input  logic [31:0] s_rd_data,
    input  logic        s_rd_valid,

    output logic [1:0]  grant,
    output logic        bus_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a master holds its rd_en/wr_en level (with addr/data stable) until its
    // one-cycle rd_valid/wr_done pulse; the slave gets one-cycle s_rd_en/s_wr_en strobes
    // and s_rd_valid is honoured only while waiting for read data.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_last;
    logic        r_owner;
    logic        r_is_wr;
    logic [15:0] r_addr;
    logic [31:0] r_wr_data;
    logic [31:0] r_rd_data;
    logic [7:0]  r_cnt;
    logic        r_err;
    logic [1:0]  r_grant;
    logic        r_s_rd_en;
    logic        r_s_wr_en;
    logic        r_m0_rd_valid;
    logic        r_m1_rd_valid;
    logic        r_m0_wr_done;
    logic        r_m1_wr_done;

    logic        w_m0_req;
    logic        w_m1_req;
    logic        w_any_req;
    logic        w_pick_m1;
    logic [15:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_wr;
    logic        w_busy;

    assign w_m0_req    = m0_rd_en | m0_wr_en;
    assign w_m1_req    = m1_rd_en | m1_wr_en;
    assign w_any_req   = w_m0_req | w_m1_req;
    // On a tie the master that did not own the previous transaction wins.
    assign w_pick_m1   = w_m1_req & (~w_m0_req | ~r_last);
    assign w_sel_addr  = w_pick_m1 ? m1_addr    : m0_addr;
    assign w_sel_wdata = w_pick_m1 ? m1_wr_data : m0_wr_data;
    assign w_sel_wr    = w_pick_m1 ? m1_wr_en   : m0_wr_en;
    assign w_busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last        <= 1'b1;
            r_owner       <= 1'b0;
            r_is_wr       <= 1'b0;
            r_addr        <= 16'h0;
            r_wr_data     <= 32'h0;
            r_rd_data     <= 32'h0;
            r_cnt         <= 8'h0;
            r_err         <= 1'b0;
            r_grant       <= 2'b00;
            r_s_rd_en     <= 1'b0;
            r_s_wr_en     <= 1'b0;
            r_m0_rd_valid <= 1'b0;
            r_m1_rd_valid <= 1'b0;
            r_m0_wr_done  <= 1'b0;
            r_m1_wr_done  <= 1'b0;
        end else begin
            r_s_rd_en     <= 1'b0;
            r_s_wr_en     <= 1'b0;
            r_m0_rd_valid <= 1'b0;
            r_m1_rd_valid <= 1'b0;
            r_m0_wr_done  <= 1'b0;
            r_m1_wr_done  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_pick_m1;
                        r_last    <= w_pick_m1;
                        r_addr    <= w_sel_addr;
                        r_wr_data <= w_sel_wdata;
                        r_is_wr   <= w_sel_wr;
                        r_grant   <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_s_rd_en <= ~w_sel_wr;
                        r_s_wr_en <= w_sel_wr;
                        r_state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (r_is_wr) begin
                        if (r_owner) begin
                            r_m1_wr_done <= 1'b1;
                        end else begin
                            r_m0_wr_done <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt   <= 8'h0;
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (s_rd_valid) begin
                        r_rd_data <= s_rd_data;
                        if (r_owner) begin
                            r_m1_rd_valid <= 1'b1;
                        end else begin
                            r_m0_rd_valid <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        // Unmapped read: complete with zero data and flag the error.
                        r_rd_data <= 32'h0;
                        r_err     <= 1'b1;
                        if (r_owner) begin
                            r_m1_rd_valid <= 1'b1;
                        end else begin
                            r_m0_rd_valid <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_RESP: begin
                    r_err   <= 1'b0;
                    r_grant <= 2'b00;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_addr      = w_busy ? r_addr    : 16'h0;
    assign s_wr_data   = w_busy ? r_wr_data : 32'h0;
    assign s_rd_en     = r_s_rd_en;
    assign s_wr_en     = r_s_wr_en;
    assign m0_rd_data  = r_rd_data;
    assign m1_rd_data  = r_rd_data;
    assign m0_rd_valid = r_m0_rd_valid;
    assign m1_rd_valid = r_m1_rd_valid;
    assign m0_wr_done  = r_m0_wr_done;
    assign m1_wr_done  = r_m1_wr_done;
    assign grant       = r_grant;
    assign bus_err     = r_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected slave strobes and master completions are queued
// at issue time and popped by independent monitors when the DUT presents them.
module tb_bus_arbiter;

    localparam int CW = 69;  // {cycle32, grant2, master, wr, err, data32}
    localparam int SW = 83;  // {cycle32, grant2, wr, addr16, wdata32}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m0_addr = 16'h0;
    logic        m0_rd_en = 1'b0;
    logic        m0_wr_en = 1'b0;
    logic [31:0] m0_wr_data = 32'h0;
    logic [31:0] m0_rd_data;
    logic        m0_rd_valid;
    logic        m0_wr_done;
    logic [15:0] m1_addr = 16'h0;
    logic        m1_rd_en = 1'b0;
    logic        m1_wr_en = 1'b0;
    logic [31:0] m1_wr_data = 32'h0;
    logic [31:0] m1_rd_data;
    logic        m1_rd_valid;
    logic        m1_wr_done;
    logic [15:0] s_addr;
    logic        s_rd_en;
    logic        s_wr_en;
    logic [31:0] s_wr_data;
    logic [31:0] s_rd_data = 32'h0;
    logic        s_rd_valid = 1'b0;
    logic [1:0]  grant;
    logic        bus_err;
    logic [1:0]  dbg_state;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [CW-1:0] exp_q[$];
    logic [SW-1:0] sexp_q[$];

    int          slave_lat = 1;
    logic [31:0] slave_data = 32'h0;
    int          stray_q[$];

    bus_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_wr_data(m0_wr_data),
        .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid), .m0_wr_done(m0_wr_done),
        .m1_addr(m1_addr), .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_wr_data(m1_wr_data),
        .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid), .m1_wr_done(m1_wr_done),
        .s_addr(s_addr), .s_rd_en(s_rd_en), .s_wr_en(s_wr_en), .s_wr_data(s_wr_data),
        .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid),
        .grant(grant), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_c(input int c, input bit m, input bit wr, input bit err, input logic [31:0] d);
        exp_q.push_back({32'(c), (m ? 2'b10 : 2'b01), m, wr, err, d});
    endtask

    task automatic push_s(input int c, input bit m, input bit wr, input logic [15:0] a, input logic [31:0] wd);
        sexp_q.push_back({32'(c), (m ? 2'b10 : 2'b01), wr, a, (wr ? wd : 32'h0)});
    endtask

    // Master driver: called #1 after a rising edge, holds the request until completion.
    task automatic master_txn(input bit m, input bit wr, input logic [15:0] a, input logic [31:0] wd);
        int n;
        bit got;
        if (m) begin
            m1_addr = a; m1_wr_data = wd; m1_rd_en = ~wr; m1_wr_en = wr;
        end else begin
            m0_addr = a; m0_wr_data = wd; m0_rd_en = ~wr; m0_wr_en = wr;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = m ? (m1_rd_valid | m1_wr_done) : (m0_rd_valid | m0_wr_done);
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL txn_wait m%0d: actual=no completion expected=completion within 200 cycles", m);
        end
        @(posedge clk);
        #1;
        if (m) begin
            m1_rd_en = 1'b0; m1_wr_en = 1'b0;
        end else begin
            m0_rd_en = 1'b0; m0_wr_en = 1'b0;
        end
    endtask

    // Slave model: answers mapped reads slave_lat cycles after s_rd_en; 0x3xxx never answers.
    initial begin
        bit pend;
        int cnt;
        bit hit;
        pend = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (s_rd_en && s_addr[15:12] != 4'h3) begin
                pend = 1'b1;
                cnt = slave_lat;
            end
            @(posedge clk);
            #1;
            hit = 1'b0;
            for (int k = 0; k < stray_q.size(); k++) begin
                if (stray_q[k] == cyc) hit = 1'b1;
            end
            if (pend && cnt == 1) begin
                s_rd_valid = 1'b1;
                s_rd_data = slave_data;
                pend = 1'b0;
            end else if (pend) begin
                cnt--;
                s_rd_valid = 1'b0;
                s_rd_data = 32'h0;
            end else if (hit) begin
                s_rd_valid = 1'b1;
                s_rd_data = 32'hBAD0BAD0;
            end else begin
                s_rd_valid = 1'b0;
                s_rd_data = 32'h0;
            end
        end
    end

    // Scoreboard monitor: master-side completions
    always @(negedge clk) begin
        logic [CW-1:0] act;
        logic [CW-1:0] exp_v;
        int np;
        bit am;
        bit aw;
        np = int'(m0_rd_valid) + int'(m0_wr_done) + int'(m1_rd_valid) + int'(m1_wr_done);
        if (np > 1) begin
            n_checks++;
            n_fail++;
            $display("FAIL multi_pulse: actual=%0d pulses expected=1 (cycle %0d)", np, cyc);
        end
        if (np >= 1) begin
            am = m1_rd_valid | m1_wr_done;
            aw = am ? m1_wr_done : m0_wr_done;
            act = {32'(cyc), grant, am, aw, bus_err, (aw ? 32'h0 : (am ? m1_rd_data : m0_rd_data))};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_completion: actual=%h expected=none", act);
            end else begin
                exp_v = exp_q.pop_front();
                if (act !== exp_v) begin
                    n_fail++;
                    $display("FAIL completion {cyc,grant,m,wr,err,data}: actual=%h expected=%h", act, exp_v);
                end
            end
        end else if (bus_err) begin
            n_checks++;
            n_fail++;
            $display("FAIL lone_bus_err: actual=1 expected=0 (cycle %0d)", cyc);
        end
    end

    // Scoreboard monitor: slave-side strobes
    always @(negedge clk) begin
        logic [SW-1:0] act;
        logic [SW-1:0] exp_v;
        if (s_rd_en || s_wr_en) begin
            act = {32'(cyc), grant, s_wr_en, s_addr, (s_wr_en ? s_wr_data : 32'h0)};
            n_checks++;
            if (sexp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: actual=%h expected=none", act);
            end else begin
                exp_v = sexp_q.pop_front();
                if (act !== exp_v) begin
                    n_fail++;
                    $display("FAIL strobe {cyc,grant,wr,addr,wdata}: actual=%h expected=%h", act, exp_v);
                end
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: actual=still running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int t;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        check("rst_s_addr", 32'(s_addr), 32'h0);
        check("rst_s_wr_data", s_wr_data, 32'h0);
        check("rst_s_strobes", 32'({s_rd_en, s_wr_en}), 32'h0);
        check("rst_m0_rd_data", m0_rd_data, 32'h0);
        check("rst_m1_rd_data", m1_rd_data, 32'h0);
        check("rst_pulses", 32'({m0_rd_valid, m0_wr_done, m1_rd_valid, m1_wr_done}), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);

        // Single read by m0, bram-like latency
        @(posedge clk); #1; t = cyc;
        slave_lat = 1; slave_data = 32'hCAFEF00D;
        push_s(t + 1, 0, 0, 16'h0010, 32'h0);
        push_c(t + 3, 0, 0, 0, 32'hCAFEF00D);
        fork
            master_txn(0, 0, 16'h0010, 32'h0);
            begin
                repeat (3) @(negedge clk);
                check("read_grant_wait", 32'(grant), 32'h1);
                check("read_s_addr_wait", 32'(s_addr), 32'h0010);
                repeat (2) @(negedge clk);
                check("read_grant_after", 32'(grant), 32'h0);
                check("read_s_addr_idle", 32'(s_addr), 32'h0);
            end
        join

        // Tie after m0 owned the bus: m1 (read, 3-cycle slave) first, then m0 write
        @(posedge clk); #1; t = cyc;
        slave_lat = 3; slave_data = 32'h0F0F1234;
        push_s(t + 1, 1, 0, 16'h1000, 32'h0);
        push_c(t + 5, 1, 0, 0, 32'h0F0F1234);
        push_s(t + 7, 0, 1, 16'h2000, 32'h55AA55AA);
        push_c(t + 8, 0, 1, 0, 32'h0);
        fork
            master_txn(1, 0, 16'h1000, 32'h0);
            master_txn(0, 1, 16'h2000, 32'h55AA55AA);
        join

        // Lone m1 write
        @(posedge clk); #1; t = cyc;
        push_s(t + 1, 1, 1, 16'h4000, 32'h12345678);
        push_c(t + 2, 1, 1, 0, 32'h0);
        fork
            master_txn(1, 1, 16'h4000, 32'h12345678);
            begin
                repeat (4) @(negedge clk);
                check("write_idle_s_wr_data", s_wr_data, 32'h0);
                check("write_idle_grant", 32'(grant), 32'h0);
            end
        join

        // Reset, then both masters continuously write: strict alternation starting with m0
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; t = cyc;
        push_s(t + 1,  0, 1, 16'h0100, 32'hA0000000);
        push_c(t + 2,  0, 1, 0, 32'h0);
        push_s(t + 4,  1, 1, 16'h0200, 32'hB0000000);
        push_c(t + 5,  1, 1, 0, 32'h0);
        push_s(t + 7,  0, 1, 16'h0101, 32'hA0000001);
        push_c(t + 8,  0, 1, 0, 32'h0);
        push_s(t + 10, 1, 1, 16'h0201, 32'hB0000001);
        push_c(t + 11, 1, 1, 0, 32'h0);
        push_s(t + 13, 0, 1, 16'h0102, 32'hA0000002);
        push_c(t + 14, 0, 1, 0, 32'h0);
        push_s(t + 16, 1, 1, 16'h0202, 32'hB0000002);
        push_c(t + 17, 1, 1, 0, 32'h0);
        fork
            for (int i = 0; i < 3; i++) begin
                if (i > 0) begin @(posedge clk); #1; end
                master_txn(0, 1, 16'h0100 + 16'(i), 32'hA0000000 + 32'(i));
            end
            for (int j = 0; j < 3; j++) begin
                if (j > 0) begin @(posedge clk); #1; end
                master_txn(1, 1, 16'h0200 + 16'(j), 32'hB0000000 + 32'(j));
            end
        join

        // Timeout on unmapped read by m0; m1 read queued behind it
        @(posedge clk); #1; t = cyc;
        slave_lat = 1; slave_data = 32'h5A5A0001;
        push_s(t + 1, 0, 0, 16'h3000, 32'h0);
        push_c(t + 18, 0, 0, 1, 32'h0);
        push_s(t + 20, 1, 0, 16'h0020, 32'h0);
        push_c(t + 22, 1, 0, 0, 32'h5A5A0001);
        fork
            master_txn(0, 0, 16'h3000, 32'h0);
            begin
                repeat (2) @(posedge clk);
                #1;
                master_txn(1, 0, 16'h0020, 32'h0);
            end
            begin
                repeat (11) @(negedge clk);
                check("timeout_state_wait", 32'(dbg_state), 32'h2);
                check("timeout_s_addr_wait", 32'(s_addr), 32'h3000);
                check("timeout_grant_wait", 32'(grant), 32'h1);
            end
        join

        // Stray s_rd_valid in IDLE and ISSUE is ignored
        @(posedge clk); #1; t = cyc;
        slave_lat = 1; slave_data = 32'h11223344;
        stray_q.push_back(t + 1);
        stray_q.push_back(t + 3);
        push_s(t + 3, 0, 0, 16'h0030, 32'h0);
        push_c(t + 5, 0, 0, 0, 32'h11223344);
        @(posedge clk); #1;
        @(negedge clk);
        check("stray_idle_state", 32'(dbg_state), 32'h0);
        check("stray_idle_rd_data", m0_rd_data, 32'h5A5A0001);
        @(posedge clk); #1;
        master_txn(0, 0, 16'h0030, 32'h0);

        // Reset while m1 waits on an unmapped read, then a fresh m1 read
        @(posedge clk); #1; t = cyc;
        m1_addr = 16'h3004; m1_rd_en = 1'b1;
        push_s(t + 1, 1, 0, 16'h3004, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rstwait_state", 32'(dbg_state), 32'h2);
        @(posedge clk); #1;
        rst = 1'b1; m1_rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstwait_grant", 32'(grant), 32'h0);
        check("rstwait_state_idle", 32'(dbg_state), 32'h0);
        check("rstwait_s_addr", 32'(s_addr), 32'h0);
        check("rstwait_m1_rd_data", m1_rd_data, 32'h0);
        check("rstwait_pulses", 32'({m0_rd_valid, m0_wr_done, m1_rd_valid, m1_wr_done, bus_err}), 32'h0);
        @(posedge clk); #1; t = cyc;
        slave_lat = 1; slave_data = 32'h600DD00D;
        push_s(t + 1, 1, 0, 16'h0040, 32'h0);
        push_c(t + 3, 1, 0, 0, 32'h600DD00D);
        master_txn(1, 0, 16'h0040, 32'h0);

        repeat (5) @(posedge clk);
        #1;
        check("completions_drained", 32'(exp_q.size()), 32'h0);
        check("strobes_drained", 32'(sexp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
